// File: rtl/conv_mem_arbiter.sv
// rtl/conv_mem_arbiter.sv - shares the conv1d single-port data memory between accelerator and host
// Anti-starvation guard (FORCE state, wait_cnt) is built only when CONV_ARB_ANTISTARVE_EN is defined.
module conv_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              acc_busy,
  input  logic              acc_req,
  input  logic              acc_we,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wdata,
  output logic              acc_gnt,
  output logic              acc_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    HOST_PRIO = 2'd0,
    ACC_PRIO  = 2'd1,
    FORCE     = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_ACC  = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  state_e state_q, state_d;
  owner_e rd_owner_q, rd_owner_d;
  logic   host_first;
  logic   force_host;

`ifdef CONV_ARB_ANTISTARVE_EN
  localparam logic [7:0] WAIT_MAX  = 8'(MAX_WAIT);
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       host_denied;

  assign host_denied = host_req & ~host_gnt;
  // Host has waited MAX_WAIT denied cycles once this cycle is also denied.
  assign force_host  = host_denied && (wait_cnt_q == WAIT_LAST);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if ((state_q != ACC_PRIO) || !host_denied) begin
      wait_cnt_d = 8'd0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= 8'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic unused_max_wait;
  assign unused_max_wait = ^8'(MAX_WAIT);
  assign force_host      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HOST_PRIO;
      rd_owner_q <= OWN_NONE;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Falling acc_busy takes precedence over a pending forced host slot.
  always_comb begin
    state_d = state_q;
    case (state_q)
      HOST_PRIO: if (acc_busy) state_d = ACC_PRIO;
      ACC_PRIO: begin
        if (!acc_busy) begin
          state_d = HOST_PRIO;
        end else if (force_host) begin
          state_d = FORCE;
        end
      end
      FORCE:     state_d = acc_busy ? ACC_PRIO : HOST_PRIO;
      default:   state_d = HOST_PRIO;
    endcase
  end

  assign host_first = (state_q != ACC_PRIO);

  // No grant is issued while reset is asserted, so nothing reaches memory.
  always_comb begin
    acc_gnt   = 1'b0;
    host_gnt  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n) begin
      host_gnt = host_req & (host_first | ~acc_req);
      acc_gnt  = acc_req & ~(host_first & host_req);
    end
    if (host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else if (acc_gnt) begin
      mem_we    = acc_we;
      mem_addr  = acc_addr;
      mem_wdata = acc_wdata;
    end
    mem_req = acc_gnt | host_gnt;
  end

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (acc_gnt && !acc_we) begin
      rd_owner_d = OWN_ACC;
    end else if (host_gnt && !host_we) begin
      rd_owner_d = OWN_HOST;
    end
  end

  assign acc_rvalid  = (rd_owner_q == OWN_ACC);
  assign host_rvalid = (rd_owner_q == OWN_HOST);
  assign rdata       = mem_rdata;

endmodule

// File: tb/tb_conv_mem_arbiter.sv
// tb/tb_conv_mem_arbiter.sv - directed self-checking bench for conv_mem_arbiter
// Honours CONV_ARB_ANTISTARVE_EN to pick the expected starvation behaviour.
module tb_conv_mem_arbiter;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              acc_busy, acc_req, acc_we, host_req, host_we;
  logic [ADDR_W-1:0] acc_addr, host_addr;
  logic [DATA_W-1:0] acc_wdata, host_wdata;
  logic              acc_gnt, acc_rvalid, host_gnt, host_rvalid;
  logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[7:0]];
    end
  end

  conv_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n), .acc_busy(acc_busy),
    .acc_req(acc_req), .acc_we(acc_we), .acc_addr(acc_addr), .acc_wdata(acc_wdata),
    .acc_gnt(acc_gnt), .acc_rvalid(acc_rvalid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    acc_req = 1'b0; acc_we = 1'b0; acc_addr = '0; acc_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; acc_busy = 1'b0; idle();
    acc_req = 1'b1; host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0044; host_wdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if (acc_gnt !== 1'b0) begin errors++; $display("FAIL rst_acc_gnt got %0b want 0", acc_gnt); end
    checks++; if (host_gnt !== 1'b0) begin errors++; $display("FAIL rst_host_gnt got %0b want 0", host_gnt); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req got %0b want 0", mem_req); end
    checks++; if ({mem_we, mem_addr, mem_wdata} !== '0) begin errors++; $display("FAIL rst_mem_bus got %0b/%h/%h want 0", mem_we, mem_addr, mem_wdata); end
    checks++; if ({acc_rvalid, host_rvalid} !== 2'b00) begin errors++; $display("FAIL rst_rvalid got %b want 00", {acc_rvalid, host_rvalid}); end
    checks++; if (dut.state_q !== 2'd0) begin errors++; $display("FAIL rst_state got %0d want 0", dut.state_q); end
    idle();
    next();
    rst_n = 1'b1;
  endtask

  task automatic test_host_rw();
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0010; host_wdata = 32'hA5A5_0001;
    @(negedge clk);
    checks++; if ({host_gnt, acc_gnt, mem_req, mem_we} !== 4'b1011) begin errors++; $display("FAIL hw_strobes got %b want 1011", {host_gnt, acc_gnt, mem_req, mem_we}); end
    checks++; if (mem_addr !== 16'h0010 || mem_wdata !== 32'hA5A5_0001) begin errors++; $display("FAIL hw_bus got %h/%h want 0010/a5a50001", mem_addr, mem_wdata); end
    next();
    host_we = 1'b0; host_wdata = '0;
    @(negedge clk);
    checks++; if ({host_gnt, mem_req, mem_we} !== 3'b110) begin errors++; $display("FAIL hr_strobes got %b want 110", {host_gnt, mem_req, mem_we}); end
    checks++; if (host_rvalid !== 1'b0) begin errors++; $display("FAIL hw_no_rvalid got %0b want 0", host_rvalid); end
    next();
    idle();
    @(negedge clk);
    checks++; if ({host_rvalid, acc_rvalid} !== 2'b10) begin errors++; $display("FAIL hr_rvalid got %b want 10", {host_rvalid, acc_rvalid}); end
    checks++; if (rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL hr_rdata got %h want a5a50001", rdata); end
    checks++; if ({mem_req, mem_addr} !== '0) begin errors++; $display("FAIL idle_mem got %0b/%h want 0/0000", mem_req, mem_addr); end
    next();
  endtask

  task automatic test_back_to_back();
    acc_req = 1'b1; acc_we = 1'b1; acc_addr = 16'h0020; acc_wdata = 32'hCAFE_0020;
    @(negedge clk);
    checks++; if ({acc_gnt, host_gnt, mem_we} !== 3'b101) begin errors++; $display("FAIL aw_strobes got %b want 101", {acc_gnt, host_gnt, mem_we}); end
    checks++; if (mem_wdata !== 32'hCAFE_0020) begin errors++; $display("FAIL aw_wdata got %h want cafe0020", mem_wdata); end
    next();
    acc_we = 1'b0; acc_wdata = '0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0010;
    @(negedge clk);
    checks++; if (acc_rvalid !== 1'b0) begin errors++; $display("FAIL aw_no_rvalid got %0b want 0", acc_rvalid); end
    checks++; if ({host_gnt, acc_gnt} !== 2'b10) begin errors++; $display("FAIL b2b_first got %b want 10", {host_gnt, acc_gnt}); end
    checks++; if (mem_addr !== 16'h0010) begin errors++; $display("FAIL b2b_addr1 got %h want 0010", mem_addr); end
    next();
    host_req = 1'b0;
    @(negedge clk);
    checks++; if ({host_gnt, acc_gnt} !== 2'b01) begin errors++; $display("FAIL b2b_second got %b want 01", {host_gnt, acc_gnt}); end
    checks++; if (mem_addr !== 16'h0020) begin errors++; $display("FAIL b2b_addr2 got %h want 0020", mem_addr); end
    checks++; if ({host_rvalid, acc_rvalid} !== 2'b10 || rdata !== 32'hA5A5_0001) begin errors++; $display("FAIL b2b_ret1 got %b/%h want 10/a5a50001", {host_rvalid, acc_rvalid}, rdata); end
    next();
    idle();
    @(negedge clk);
    checks++; if ({host_rvalid, acc_rvalid} !== 2'b01 || rdata !== 32'hCAFE_0020) begin errors++; $display("FAIL b2b_ret2 got %b/%h want 01/cafe0020", {host_rvalid, acc_rvalid}, rdata); end
    next();
  endtask

  task automatic test_starvation();
    logic exp_h;
    acc_busy = 1'b1;
    next();
    acc_req = 1'b1; acc_addr = 16'h0020; host_req = 1'b1; host_addr = 16'h0010;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
`ifdef CONV_ARB_ANTISTARVE_EN
      exp_h = (i == 8) || (i == 17);
`else
      exp_h = 1'b0;
`endif
      checks++; if (host_gnt !== exp_h) begin errors++; $display("FAIL starve_host_gnt[%0d] got %0b want %0b", i, host_gnt, exp_h); end
      checks++; if (acc_gnt !== ~exp_h) begin errors++; $display("FAIL starve_acc_gnt[%0d] got %0b want %0b", i, acc_gnt, ~exp_h); end
      next();
    end
    idle();
    acc_busy = 1'b0;
    next();
    @(negedge clk);
    checks++; if (dut.state_q !== 2'd0) begin errors++; $display("FAIL starve_exit_state got %0d want 0", dut.state_q); end
    next();
  endtask

  task automatic test_busy_fall();
    acc_busy = 1'b1;
    next();
    acc_req = 1'b1; acc_addr = 16'h0020; host_req = 1'b1; host_addr = 16'h0010;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      checks++; if ({acc_gnt, host_gnt} !== 2'b10) begin errors++; $display("FAIL fall_pre[%0d] got %b want 10", i, {acc_gnt, host_gnt}); end
      next();
    end
    acc_busy = 1'b0;
    @(negedge clk);
    checks++; if ({acc_gnt, host_gnt} !== 2'b10) begin errors++; $display("FAIL fall_cycle got %b want 10", {acc_gnt, host_gnt}); end
`ifdef CONV_ARB_ANTISTARVE_EN
    checks++; if (dut.wait_cnt_q !== 8'd7) begin errors++; $display("FAIL fall_wait_cnt got %0d want 7", dut.wait_cnt_q); end
`endif
    next();
    @(negedge clk);
    checks++; if (dut.state_q !== 2'd0) begin errors++; $display("FAIL fall_state got %0d want 0", dut.state_q); end
    checks++; if ({acc_gnt, host_gnt} !== 2'b01) begin errors++; $display("FAIL fall_host got %b want 01", {acc_gnt, host_gnt}); end
    next();
    host_req = 1'b0;
    @(negedge clk);
    checks++; if ({acc_gnt, host_gnt} !== 2'b10) begin errors++; $display("FAIL fall_acc_after got %b want 10", {acc_gnt, host_gnt}); end
    next();
    idle();
  endtask

  task automatic test_reset_mid();
    acc_busy = 1'b1;
    next();
    acc_req = 1'b1; acc_addr = 16'h0003; host_req = 1'b1; host_addr = 16'h0010;
    @(negedge clk);
    checks++; if ({acc_gnt, host_gnt} !== 2'b10) begin errors++; $display("FAIL rm_gnt got %b want 10", {acc_gnt, host_gnt}); end
    next();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({acc_rvalid, host_rvalid} !== 2'b00) begin errors++; $display("FAIL rm_rvalid got %b want 00", {acc_rvalid, host_rvalid}); end
    checks++; if ({acc_gnt, host_gnt, mem_req, mem_we} !== 4'b0000) begin errors++; $display("FAIL rm_strobes got %b want 0000", {acc_gnt, host_gnt, mem_req, mem_we}); end
    checks++; if ({mem_addr, mem_wdata} !== '0) begin errors++; $display("FAIL rm_bus got %h/%h want 0", mem_addr, mem_wdata); end
    checks++; if (dut.state_q !== 2'd0) begin errors++; $display("FAIL rm_state got %0d want 0", dut.state_q); end
`ifdef CONV_ARB_ANTISTARVE_EN
    checks++; if (dut.wait_cnt_q !== 8'd0) begin errors++; $display("FAIL rm_wait_cnt got %0d want 0", dut.wait_cnt_q); end
`endif
    idle();
    acc_busy = 1'b0;
    next();
    rst_n = 1'b1;
    acc_req = 1'b1; acc_addr = 16'h0020;
    @(negedge clk);
    checks++; if ({acc_gnt, mem_addr} !== {1'b1, 16'h0020}) begin errors++; $display("FAIL rm_reissue got %0b/%h want 1/0020", acc_gnt, mem_addr); end
    next();
    idle();
    @(negedge clk);
    checks++; if (acc_rvalid !== 1'b1 || rdata !== 32'hCAFE_0020) begin errors++; $display("FAIL rm_reissue_data got %0b/%h want 1/cafe0020", acc_rvalid, rdata); end
    next();
  endtask

  initial begin
    test_reset();
    test_host_rw();
    test_back_to_back();
    test_starvation();
    test_busy_fall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_mem_arbiter.md
# conv_mem_arbiter

Two-requester arbiter that shares the conv1d accelerator's single-port data memory between the accelerator control unit and the host load/unload port. It sits between both masters and the memory macro. It grants one access per cycle and routes the 1-cycle-latency read data back to the issuing master. While a convolution job runs, the accelerator has priority, but a starvation guard still lets the host in periodically.

## Interface
Parameters:
- ADDR_W, 16, memory word address width
- DATA_W, 32, memory data width
- MAX_WAIT, 8, consecutive denied host cycles before a forced host grant (range 1..255)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- acc_busy  in  1  accelerator job in progress (high from start until done)
- acc_req  in  1  accelerator access request
- acc_we  in  1  accelerator write enable
- acc_addr  in  ADDR_W  accelerator address
- acc_wdata  in  DATA_W  accelerator write data
- acc_gnt  out  1  accelerator access accepted this cycle
- acc_rvalid  out  1  read data for accelerator valid
- host_req  in  1  host access request
- host_we  in  1  host write enable
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_gnt  out  1  host access accepted this cycle
- host_rvalid  out  1  read data for host valid
- rdata  out  DATA_W  read data, shared by both masters
- mem_req, mem_we  out  1  memory strobe and write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after a read strobe

## Operation
- Handshake:
  - A master holds req, we, addr and wdata stable until it sees gnt high.
  - Exactly one access is transferred per gnt cycle.
  - acc_gnt and host_gnt are never high together.
- Memory side:
  - mem_req is the OR of the two gnt signals.
  - mem_we, mem_addr and mem_wdata are muxed from the granted master.
  - When neither master is granted, mem_we=0, mem_addr=0 and mem_wdata=0.
- Arbitration FSM, 3 states:
  - HOST_PRIO (reset state)
    - Priority: host over acc.
    - Exit: to ACC_PRIO when acc_busy=1.
  - ACC_PRIO
    - Priority: acc over host.
    - Exit: to FORCE when wait_cnt reaches MAX_WAIT-1 and the host is denied again this cycle.
    - Exit: to HOST_PRIO when acc_busy=0.
  - FORCE
    - Lasts one cycle.
    - Priority: host over acc.
    - Exit: to ACC_PRIO if acc_busy=1, otherwise to HOST_PRIO.
  - Precedence: the acc_busy=0 exit out of ACC_PRIO wins over the FORCE transition.
- wait_cnt (8 bits):
  - Increments in ACC_PRIO on each cycle with host_req=1 and host_gnt=0.
  - Clears on any host_gnt, on host_req=0, and in HOST_PRIO.
  - Saturates at MAX_WAIT.
- Read return:
  - rd_owner register, values NONE/ACC/HOST.
  - Loaded on each cycle from the granted master if the grant is a read (we=0), else NONE.
  - The next cycle raises acc_rvalid or host_rvalid accordingly.
  - rdata = mem_rdata, passed through combinationally.
  - Writes produce no response.
- Back-to-back grants are allowed. Reads from alternating masters on consecutive cycles return in grant order.

## Timing
- gnt is combinational from req and the current state (zero added latency).
- Read latency is grant cycle + 1 for rvalid.
- A granted read therefore has the same timing as a direct memory connection.
- Reset values:
  - state=HOST_PRIO, wait_cnt=0, rd_owner=NONE.
  - All gnt, rvalid and mem_* outputs are 0.
- Reset mid-operation: a pending rvalid is dropped and no grant is issued while rst_n=0. The requester re-issues after reset.
- acc_busy changes take effect on arbitration from the next cycle only (registered through the state).
- Simultaneous requests:
  - One master is denied per cycle and retries with its request held.
  - The denied master's signals never reach memory.

## Configuration
- CONV_ARB_ANTISTARVE_EN:
  - Defined: FORCE state and wait_cnt are present as described.
  - Undefined: FORCE is never entered and wait_cnt is removed. In ACC_PRIO the accelerator has strict priority, so the host may stall for an entire job.

## Test plan
- Reset, then host-only write of 0xA5A5_0001 to addr 0x10, then host read of 0x10 -> host_gnt in the request cycle; host_rvalid next cycle with rdata=0xA5A5_0001; acc_rvalid stays 0.
- acc_busy=1, both masters request reads every cycle for 20 cycles, MAX_WAIT=8, macro defined -> acc granted 8 consecutive cycles, then host granted on the 9th; pattern repeats; no cycle with both gnts.
- Same stimulus with CONV_ARB_ANTISTARVE_EN undefined -> host_gnt=0 for all 20 cycles; acc granted every cycle.
- acc_busy=0, simultaneous acc and host requests -> host granted first, acc granted the following cycle; rvalid routed to host then acc on successive cycles.
- Acc read of addr 0x3 granted, rst_n pulsed low the next cycle -> acc_rvalid=0; all outputs 0 during reset; FSM back in HOST_PRIO with wait_cnt=0.
- acc_busy falls in ACC_PRIO with wait_cnt=7 and host denied that cycle -> next state is HOST_PRIO (not FORCE); host granted next cycle.
